vdg_pixel_serialiser: RTL and testbench

Parametrised pixel back-end for the next-generation VDG: fetches display bytes over a request/acknowledge handshake into a small FIFO and serialises them at 1, 2 or 4 bits per pixel into 4-bit VDG colour codes. It sits between the display-memory fetch logic and the palette/RGB stage. It replaces the fixed load/shift/colour-map chain with one block that buffers its input, runs per line, and reports underrun.

---
 rtl/vdg_pkg.sv | 42 ++++
 rtl/vdg_sync_fifo.sv | 66 ++++++
 rtl/vdg_pixel_serialiser.sv | 207 ++++++++++++++++++++
 tb/tb_vdg_pixel_serialiser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vdg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdg_pkg
// Description : Shared constants, state encoding and bits-per-pixel lookup
//               for the VDG pixel back-end.
// Revision    : 1.0  initial release
// ============================================================================
package vdg_pkg;

    // Pixel modes as carried on the Mode input; 2'b11 behaves as 2bpp
    localparam logic [1:0] c_mode_1bpp = 2'b00;
    localparam logic [1:0] c_mode_2bpp = 2'b01;
    localparam logic [1:0] c_mode_4bpp = 2'b10;

    // VDG colour codes
    localparam logic [3:0] c_vdg_green   = 4'h0;
    localparam logic [3:0] c_vdg_yellow  = 4'h1;
    localparam logic [3:0] c_vdg_blue    = 4'h2;
    localparam logic [3:0] c_vdg_red     = 4'h3;
    localparam logic [3:0] c_vdg_buff    = 4'h4;
    localparam logic [3:0] c_vdg_cyan    = 4'h5;
    localparam logic [3:0] c_vdg_magenta = 4'h6;
    localparam logic [3:0] c_vdg_orange  = 4'h7;
    localparam logic [3:0] c_vdg_black   = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // Bits per pixel for a given mode; anything unrecognised is 2bpp
    function automatic logic [2:0] bpp_of(input logic [1:0] mode);
        case (mode)
            c_mode_1bpp: return 3'd1;
            c_mode_4bpp: return 3'd4;
            default:     return 3'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdg_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vdg_sync_fifo
// Description : Small first-word-fall-through synchronous FIFO holding the
//               prefetched display bytes. Flush has priority over push/pop.
// Revision    : 1.0  initial release
// ============================================================================
module vdg_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int              c_aw         = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_full_count = (c_aw+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]   wr_ptr_q;
    logic [c_aw-1:0]   rd_ptr_q;
    logic [c_aw:0]     count_q;
    logic              w_push;
    logic              w_pop;

    assign full   = (count_q == c_full_count);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array: written on accepted push, never reset
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vdg_pixel_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : vdg_pixel_serialiser
// Description : Fetches display bytes into a prefetch FIFO and serialises
//               them at 1/2/4 bpp into registered VDG colour codes, one line
//               per LineStart, with a sticky underrun flag.
//               Build option VDG_BORDER_EN: when defined the border colour
//               follows BorderColour, otherwise it is fixed black (4'h8).
// Revision    : 1.0  initial release
// ============================================================================
module vdg_pixel_serialiser #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACTIVE_BYTES = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              PixEn,
    input  logic              LineStart,
    input  logic [1:0]        Mode,
    input  logic              Css,
    input  logic [3:0]        BorderColour,
    output logic              FetchReq,
    input  logic              FetchAck,
    input  logic [DATA_W-1:0] FetchData,
    output logic [3:0]        Colour,
    output logic              Active,
    output logic              LineDone,
    output logic              Underrun
);
    import vdg_pkg::*;

    localparam int               c_cnt_w       = $clog2(FIFO_DEPTH) + 1;
    localparam int               c_pix_w       = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_half      = c_cnt_w'(FIFO_DEPTH / 2);
    localparam logic [8:0]       c_active      = 9'(ACTIVE_BYTES);
    localparam logic [8:0]       c_active_last = 9'(ACTIVE_BYTES - 1);
    localparam logic [c_pix_w-1:0] c_last_1bpp = c_pix_w'(DATA_W - 1);
    localparam logic [c_pix_w-1:0] c_last_2bpp = c_pix_w'(DATA_W / 2 - 1);
    localparam logic [c_pix_w-1:0] c_last_4bpp = c_pix_w'(DATA_W / 4 - 1);

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [c_pix_w-1:0]   pix_cnt_q, pix_cnt_d;
    logic [8:0]           byte_cnt_q, byte_cnt_d;
    logic [8:0]           fetch_cnt_q, fetch_cnt_d;
    logic                 underrun_q, underrun_d;
    logic                 line_done_q, line_done_d;
    logic [3:0]           colour_q, colour_d;

    logic                 w_push, w_pop;
    logic [DATA_W-1:0]    w_fifo_rdata;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic                 w_fifo_full, w_fifo_empty;
    logic [3:0]           w_border;
    logic [3:0]           w_pix_colour;
    logic [c_pix_w-1:0]   w_last_idx;

`ifdef VDG_BORDER_EN
    assign w_border = BorderColour;
`else
    logic w_border_unused;
    assign w_border        = c_vdg_black;
    assign w_border_unused = ^BorderColour;
`endif

    vdg_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (LineStart),
        .wdata (FetchData),
        .rdata (w_fifo_rdata),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Request purely from registered state so it is glitch-free to memory
    assign FetchReq = (state_q != ST_IDLE) && !w_fifo_full && (fetch_cnt_q < c_active);
    // A LineStart flush wins over a same-cycle acknowledge
    assign w_push   = FetchReq && FetchAck && !LineStart;

    assign Colour   = colour_q;
    assign Active   = (state_q == ST_SHIFT);
    assign LineDone = line_done_q;
    assign Underrun = underrun_q;

    // Colour map of the pixel group at the top of the shifter, and the
    // index of the last group in a byte for the latched mode
    always_comb begin
        w_pix_colour = c_vdg_black;
        w_last_idx   = c_last_2bpp;
        case (mode_q)
            c_mode_1bpp: begin
                w_pix_colour = shreg_q[DATA_W-1] ? (Css ? c_vdg_buff : c_vdg_green) : c_vdg_black;
                w_last_idx   = c_last_1bpp;
            end
            c_mode_4bpp: begin
                w_pix_colour = shreg_q[DATA_W-1 -: 4];
                w_last_idx   = c_last_4bpp;
            end
            default: begin
                w_pix_colour = {1'b0, Css, shreg_q[DATA_W-1 -: 2]};
                w_last_idx   = c_last_2bpp;
            end
        endcase
    end

    // Line sequencing, shifter, counters and colour register next state
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        pix_cnt_d   = pix_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        underrun_d  = underrun_q;
        line_done_d = 1'b0;
        w_pop       = 1'b0;

        if (state_q == ST_SHIFT) begin
            colour_d = (PixEn && !LineStart) ? w_pix_colour : colour_q;
        end else begin
            colour_d = w_border;
        end

        if (w_push) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end

        if (LineStart) begin
            state_d     = ST_FILL;
            mode_d      = Mode;
            fetch_cnt_d = '0;
            byte_cnt_d  = '0;
            pix_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (w_fifo_count >= c_half) begin
                        state_d   = ST_SHIFT;
                        w_pop     = 1'b1;
                        shreg_d   = w_fifo_rdata;
                        pix_cnt_d = '0;
                    end
                end
                ST_SHIFT: begin
                    if (PixEn) begin
                        if (pix_cnt_q != w_last_idx) begin
                            shreg_d   = shreg_q << bpp_of(mode_q);
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end else begin
                            pix_cnt_d  = '0;
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            if (byte_cnt_q == c_active_last) begin
                                state_d     = ST_IDLE;
                                line_done_d = 1'b1;
                            end else if (!w_fifo_empty) begin
                                w_pop   = 1'b1;
                                shreg_d = w_fifo_rdata;
                            end else begin
                                // Starved slot still counts toward the line
                                shreg_d     = '0;
                                underrun_d  = 1'b1;
                                fetch_cnt_d = fetch_cnt_d + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= c_mode_1bpp;
            shreg_q     <= '0;
            pix_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            underrun_q  <= 1'b0;
            line_done_q <= 1'b0;
            colour_q    <= w_border;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            pix_cnt_q   <= pix_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            underrun_q  <= underrun_d;
            line_done_q <= line_done_d;
            colour_q    <= colour_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vdg_pixel_serialiser.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdg_pixel_serialiser
// Description : Directed self-checking bench for vdg_pixel_serialiser with
//               DATA_W=8, FIFO_DEPTH=4, ACTIVE_BYTES=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vdg_pixel_serialiser;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int AB = 4;

    logic          Clk = 1'b0;
    logic          Reset, PixEn, LineStart, Css, FetchAck;
    logic [1:0]    Mode;
    logic [3:0]    BorderColour;
    logic [DW-1:0] FetchData;
    logic          FetchReq, Active, LineDone, Underrun;
    logic [3:0]    Colour;

    int            errors = 0;
    int            checks = 0;
    logic [7:0]    bytes [4];
    int            fidx;
    int            ack_limit;
    logic [3:0]    exp_pix [$];
    logic [3:0]    got_pix [$];

    vdg_pixel_serialiser #(
        .DATA_W       (DW),
        .FIFO_DEPTH   (FD),
        .ACTIVE_BYTES (AB)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PixEn        (PixEn),
        .LineStart    (LineStart),
        .Mode         (Mode),
        .Css          (Css),
        .BorderColour (BorderColour),
        .FetchReq     (FetchReq),
        .FetchAck     (FetchAck),
        .FetchData    (FetchData),
        .Colour       (Colour),
        .Active       (Active),
        .LineDone     (LineDone),
        .Underrun     (Underrun)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: memory model acks while fidx < ack_limit, then sample at +1
    task automatic step();
        logic took;
        FetchAck  = (fidx < ack_limit);
        FetchData = (fidx < 4) ? bytes[fidx] : 8'h00;
        took      = FetchReq && FetchAck && !LineStart && !Reset;
        @(posedge Clk);
        #1;
        if (took) fidx++;
    endtask

    task automatic push_exp(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            exp_pix.push_back((c >= "A") ? 4'(c - "A" + 10) : 4'(c - "0"));
        end
    endtask

    task automatic run_line(input string tag, input logic [1:0] mode, input logic css,
                            input int period, input int limit);
        int   cyc, act_cycles, ld_cnt, holds_bad;
        bit   done;
        logic fire;
        got_pix.delete();
        Mode = mode; Css = css; fidx = 0; ack_limit = limit; PixEn = 1'b0;
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        Mode = ~mode;
        check_eq({tag, "_start_active"},   32'(Active),   32'd0);
        check_eq({tag, "_start_fetchreq"}, 32'(FetchReq), 32'd1);
        check_eq({tag, "_start_linedone"}, 32'(LineDone), 32'd0);
        cyc = 0; act_cycles = 0; ld_cnt = 0; holds_bad = 0; done = 1'b0;
        while (!done && cyc < 400) begin
            PixEn = ((cyc % period) == 0);
            fire  = PixEn && Active;
            step();
            cyc++;
            if (fire) got_pix.push_back(Colour);
            else if (got_pix.size() > 0 && Colour !== got_pix[$]) holds_bad++;
            if (Active) act_cycles++;
            if (LineDone) begin
                ld_cnt++;
                done = 1'b1;
            end
        end
        check_eq({tag, "_linedone_seen"}, 32'(ld_cnt), 32'd1);
        check_eq({tag, "_npix"}, 32'(got_pix.size()), 32'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size(); i++) begin
            if (i < got_pix.size())
                check_eq($sformatf("%s_pix%0d", tag, i), 32'(got_pix[i]), 32'(exp_pix[i]));
        end
        if (period == 1) check_eq({tag, "_active_cycles"}, 32'(act_cycles), 32'(exp_pix.size()));
        check_eq({tag, "_colour_hold"}, 32'(holds_bad), 32'd0);
        PixEn = 1'b0;
        step();
        check_eq({tag, "_linedone_pulse"}, 32'(LineDone), 32'd0);
        check_eq({tag, "_idle_colour"},    32'(Colour),   32'h8);
        check_eq({tag, "_idle_active"},    32'(Active),   32'd0);
    endtask

    // Start a 1bpp line and stop after npix pixels, leaving it mid-line
    task automatic start_partial(input string tag, input int npix);
        int   n, cyc;
        logic fire;
        Mode = 2'b00; Css = 1'b0; fidx = 0; ack_limit = 2; PixEn = 1'b0;
        LineStart = 1'b1;
        step();
        LineStart = 1'b0;
        PixEn = 1'b1;
        n = 0; cyc = 0;
        while (n < npix && cyc < 100) begin
            fire = PixEn && Active;
            step();
            cyc++;
            if (fire) n++;
        end
        PixEn = 1'b0;
        check_eq({tag, "_partial_pixels"}, 32'(n), 32'(npix));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; PixEn = 1'b0; LineStart = 1'b0; Mode = 2'b00; Css = 1'b0;
        BorderColour = 4'h3; FetchAck = 1'b0; FetchData = '0;
        fidx = 0; ack_limit = 0;
        bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) step();
        check_eq("reset_colour",   32'(Colour),   32'h8);
        check_eq("reset_active",   32'(Active),   32'd0);
        check_eq("reset_fetchreq", 32'(FetchReq), 32'd0);
        check_eq("reset_linedone", 32'(LineDone), 32'd0);
        check_eq("reset_underrun", 32'(Underrun), 32'd0);
        Reset = 1'b0;
        step();

        // 1bpp, Css=1: set bits -> buff (4), clear bits -> black (8)
        bytes = '{8'hA5, 8'hFF, 8'h00, 8'h0F};
        exp_pix.delete();
        push_exp("48488484"); push_exp("44444444"); push_exp("88888888"); push_exp("88884444");
        run_line("bpp1", 2'b00, 1'b1, 1, 4);
        check_eq("bpp1_underrun", 32'(Underrun), 32'd0);

        // 2bpp, Css=0: {0,0,p}
        bytes = '{8'h1B, 8'hE4, 8'h1B, 8'hE4};
        exp_pix.delete();
        push_exp("0123321001233210");
        run_line("bpp2_css0", 2'b01, 1'b0, 1, 4);

        // Mode 11 behaves as 2bpp, Css=1: {0,1,p}
        exp_pix.delete();
        push_exp("4567765445677654");
        run_line("bpp2_css1", 2'b11, 1'b1, 1, 4);

        // 4bpp with PixEn every second cycle
        bytes = '{8'h3C, 8'h3C, 8'hA5, 8'h0F};
        exp_pix.delete();
        push_exp("3C3CA50F");
        run_line("bpp4", 2'b10, 1'b0, 2, 4);
        check_eq("bpp4_underrun", 32'(Underrun), 32'd0);

        // Only two bytes acknowledged: remaining slots shift out as zero
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        exp_pix.delete();
        push_exp("12340000");
        run_line("underrun", 2'b10, 1'b0, 1, 2);
        check_eq("underrun_set", 32'(Underrun), 32'd1);

        // LineStart mid-SHIFT with a same-cycle acknowledge
        bytes = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
        start_partial("restart", 3);
        check_eq("restart_req_before", 32'(FetchReq), 32'd1);
        bytes = '{8'h80, 8'h01, 8'hF0, 8'h55};
        exp_pix.delete();
        push_exp("08888888"); push_exp("88888880"); push_exp("00008888"); push_exp("80808080");
        run_line("restart", 2'b00, 1'b0, 1, 4);
        check_eq("underrun_sticky", 32'(Underrun), 32'd1);

        // Reset mid-line with FetchAck held high
        bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        start_partial("midreset", 3);
        ack_limit = 100;
        Reset = 1'b1;
        step();
        check_eq("midreset_colour",   32'(Colour),   32'h8);
        check_eq("midreset_active",   32'(Active),   32'd0);
        check_eq("midreset_fetchreq", 32'(FetchReq), 32'd0);
        check_eq("midreset_underrun", 32'(Underrun), 32'd0);
        check_eq("midreset_linedone", 32'(LineDone), 32'd0);
        Reset = 1'b0;
        ack_limit = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
